// File: rtl/car_pkg.sv
// Shared definitions for the player car controller: road edges, the default
// step size, the Wishbone register offsets and the movement FSM encoding.
// The VGA and road blocks use the same edge constants.
package car_pkg;

    localparam logic [9:0] CAR_X_MIN        = 10'd140;
    localparam logic [9:0] CAR_X_MAX        = 10'd460;
    localparam logic [9:0] CAR_X_CENTRE     = 10'd269;
    localparam logic [3:0] CAR_STEP_DEFAULT = 4'd4;

    // Word offsets, decoded from wb_adr_i[5:2]
    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_POS    = 4'd1;
    localparam logic [3:0] REG_STATUS = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE_L  = 2'd1,
        ST_MOVE_R  = 2'd2,
        ST_BLOCKED = 2'd3
    } car_state_t;

    function automatic logic [9:0] clamp_x(input logic [9:0] x,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        if (x < lo)
            return lo;
        else if (x > hi)
            return hi;
        else
            return x;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one pushbutton.
// Ports:
//   clk   - block clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous raw button level
//   level - debounced level; follows raw DEBOUNCE_CYCLES+2 cycles after a
//           change that stays stable for the whole window
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample restarts the window
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_car_ctrl.sv
// Player car horizontal position controller with a Wishbone slave port.
// Debounced left/right buttons step the car at a fixed cadence inside the road
// edges; the centre button or a CTRL write recentres it; the CPU can read
// position/status, set the step size and force a position.
// Ports:
//   wb_clk_i, wb_rst_i        - clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i      - Wishbone slave inputs (adr[5:2] decoded)
//   wb_dat_o, wb_ack_o        - read data (valid with ack), acknowledge
//   btn_left_i/right_i/centre_i - raw asynchronous buttons
//   car_x_o                   - registered car X position
//   car_x_upd_o               - one-cycle pulse the cycle after car_x_o changes
module player_car_ctrl
    import car_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 833333,
    parameter logic [9:0]  X_MIN           = CAR_X_MIN,
    parameter logic [9:0]  X_MAX           = CAR_X_MAX,
    parameter logic [9:0]  X_CENTRE        = CAR_X_CENTRE,
    parameter logic [3:0]  STEP_DEFAULT    = CAR_STEP_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        btn_left_i,
    input  logic        btn_right_i,
    input  logic        btn_centre_i,
    output logic [9:0]  car_x_o,
    output logic        car_x_upd_o
);

    localparam int unsigned      TMR_W    = $clog2(STEP_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);

    logic             left_db, right_db, centre_db, centre_q;
    logic             enable;
    logic [3:0]       step_px;
    car_state_t       state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic [9:0]       x_prev, x_next, pos_wr_val, left_x, right_x;
    logic [3:0]       reg_sel;
    logic             wr_en, pos_wr, ctrl_wr, recentre, moving, do_step;
    logic [31:0]      rdata;
    logic             unused_bits;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(wb_clk_i), .rst(wb_rst_i), .raw(btn_left_i), .level(left_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(wb_clk_i), .rst(wb_rst_i), .raw(btn_right_i), .level(right_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_centre (
        .clk(wb_clk_i), .rst(wb_rst_i), .raw(btn_centre_i), .level(centre_db)
    );

    assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:17],
                           wb_dat_i[15:12], wb_dat_i[7:1], wb_sel_i[3]};

    assign reg_sel = wb_adr_i[5:2];
    // Writes land on the edge that ends the ack cycle
    assign wr_en   = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;
    assign ctrl_wr = wr_en && (reg_sel == REG_CTRL);
    assign pos_wr  = wr_en && (reg_sel == REG_POS) && (wb_sel_i[0] || wb_sel_i[1]);
    assign recentre = (ctrl_wr && wb_sel_i[2] && wb_dat_i[16]) || (centre_db && !centre_q);

    // POS[9:0] straddles byte lanes 0 and 1; unselected lanes keep current bits
    assign pos_wr_val = clamp_x({wb_sel_i[1] ? wb_dat_i[9:8] : car_x_o[9:8],
                                 wb_sel_i[0] ? wb_dat_i[7:0] : car_x_o[7:0]},
                                X_MIN, X_MAX);

    // 11-bit compares so the edge tests cannot wrap
    assign left_x  = ({1'b0, car_x_o} <= ({1'b0, X_MIN} + {7'b0, step_px}))
                     ? X_MIN : car_x_o - {6'b0, step_px};
    assign right_x = ({1'b0, car_x_o} >= ({1'b0, X_MAX} - {7'b0, step_px}))
                     ? X_MAX : car_x_o + {6'b0, step_px};

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (left_db && right_db)  state_next = ST_BLOCKED;
                    else if (left_db)         state_next = ST_MOVE_L;
                    else if (right_db)        state_next = ST_MOVE_R;
                end
                ST_MOVE_L: begin
                    if (!left_db)             state_next = ST_IDLE;
                    else if (right_db)        state_next = ST_BLOCKED;
                end
                ST_MOVE_R: begin
                    if (!right_db)            state_next = ST_IDLE;
                    else if (left_db)         state_next = ST_BLOCKED;
                end
                default: begin
                    if (!left_db && !right_db) state_next = ST_IDLE;
                    else if (!right_db)        state_next = ST_MOVE_L;
                    else if (!left_db)         state_next = ST_MOVE_R;
                end
            endcase
        end
    end

    // Entering a move state steps at once; staying steps on timer wrap
    always_comb begin
        moving     = (state_next == ST_MOVE_L) || (state_next == ST_MOVE_R);
        do_step    = moving && ((state_next != state) || (timer == TMR_LAST));
        timer_next = '0;
        if (moving && (state_next == state) && (timer != TMR_LAST))
            timer_next = timer + 1'b1;
        x_next = car_x_o;
        if (pos_wr)
            x_next = pos_wr_val;
        else if (recentre)
            x_next = X_CENTRE;
        else if (do_step)
            x_next = (state_next == ST_MOVE_L) ? left_x : right_x;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            enable      <= 1'b1;
            step_px     <= STEP_DEFAULT;
            state       <= ST_IDLE;
            timer       <= '0;
            car_x_o     <= X_CENTRE;
            x_prev      <= X_CENTRE;
            car_x_upd_o <= 1'b0;
            centre_q    <= 1'b0;
        end else begin
            wb_ack_o    <= !wb_ack_o && wb_stb_i && wb_cyc_i;
            if (ctrl_wr && wb_sel_i[0]) enable  <= wb_dat_i[0];
            if (ctrl_wr && wb_sel_i[1]) step_px <= wb_dat_i[11:8];
            state       <= state_next;
            timer       <= timer_next;
            car_x_o     <= x_next;
            x_prev      <= car_x_o;
            car_x_upd_o <= (car_x_o != x_prev);
            centre_q    <= centre_db;
        end
    end

    // Read data is only driven during ack so the bus idles at zero
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[0]    = enable;
                rdata[11:8] = step_px;
            end
            REG_POS:    rdata[9:0] = car_x_o;
            REG_STATUS: begin
                rdata[0]   = left_db;
                rdata[1]   = right_db;
                rdata[2]   = centre_db;
                rdata[3]   = (car_x_o == X_MIN);
                rdata[4]   = (car_x_o == X_MAX);
                rdata[6:5] = state;
            end
            default: rdata = '0;
        endcase
        wb_dat_o = wb_ack_o ? rdata : '0;
    end

endmodule

// File: tb/tb_player_car_ctrl.sv
// Directed bench for player_car_ctrl with short debounce/step timings.
module tb_player_car_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w, dat_r;
    logic [3:0]  sel;
    logic        ack;
    logic        b_left, b_right, b_centre;
    logic [9:0]  car_x;
    logic        upd;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned upd_cnt  = 0;

    player_car_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
        .wb_dat_o(dat_r), .wb_ack_o(ack),
        .btn_left_i(b_left), .btn_right_i(b_right), .btn_centre_i(b_centre),
        .car_x_o(car_x), .car_x_upd_o(upd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (upd === 1'b1) upd_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        cyc = 1; stb = 1; we = 1; adr = {26'b0, r, 2'b0}; dat_w = d; sel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL wb_write_ack: no ack within 4 cycles, required ack"); end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [3:0] r, output logic [31:0] d);
        bit got = 0;
        d = 'x;
        cyc = 1; stb = 1; we = 0; adr = {26'b0, r, 2'b0}; sel = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin got = 1; d = dat_r; end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL wb_read_ack: no ack within 4 cycles, required ack"); end
        @(posedge clk); #1;
        cyc = 0; stb = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1; tick(3); rst = 0; tick(1);
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL reset_x: got %0d required 269", car_x); end
        n_checks++; if (upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b required 0", upd); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %b required 0", ack); end
            tick(1);
        end
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h required 0", rd); end
        wb_read(4'd0, rd);
        n_checks++; if (rd !== 32'h401) begin n_fail++; $display("FAIL reset_ctrl: got %h required 401", rd); end
        wb_read(4'd1, rd);
        n_checks++; if (rd !== 32'd269) begin n_fail++; $display("FAIL reset_pos: got %0d required 269", rd); end
    endtask

    task automatic test_hold_left();
        int unsigned base = upd_cnt;
        b_left = 1;
        tick(6);
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL left_pre_latency: got %0d required 269", car_x); end
        tick(1);
        n_checks++; if (car_x !== 10'd265) begin n_fail++; $display("FAIL left_step1: got %0d required 265", car_x); end
        tick(1);
        n_checks++; if (upd !== 1'b1) begin n_fail++; $display("FAIL upd_timing: got %b required 1", upd); end
        tick(7);
        n_checks++; if (car_x !== 10'd261) begin n_fail++; $display("FAIL left_step2: got %0d required 261", car_x); end
        tick(8);
        n_checks++; if (car_x !== 10'd257) begin n_fail++; $display("FAIL left_step3: got %0d required 257", car_x); end
        tick(8);
        n_checks++; if (car_x !== 10'd253) begin n_fail++; $display("FAIL left_step4: got %0d required 253", car_x); end
        tick(1); b_left = 0; tick(20);
        n_checks++; if (car_x !== 10'd253) begin n_fail++; $display("FAIL left_release: got %0d required 253", car_x); end
        n_checks++; if (upd_cnt - base !== 4) begin n_fail++; $display("FAIL left_upd_count: got %0d required 4", upd_cnt - base); end
    endtask

    task automatic test_clamp_min();
        logic [31:0] rd;
        int unsigned base;
        wb_write(4'd1, 32'd150, 4'hF);
        n_checks++; if (car_x !== 10'd150) begin n_fail++; $display("FAIL pos_write_150: got %0d required 150", car_x); end
        tick(3); base = upd_cnt;
        b_left = 1;
        tick(7);
        n_checks++; if (car_x !== 10'd146) begin n_fail++; $display("FAIL min_step1: got %0d required 146", car_x); end
        tick(8);
        n_checks++; if (car_x !== 10'd142) begin n_fail++; $display("FAIL min_step2: got %0d required 142", car_x); end
        tick(8);
        n_checks++; if (car_x !== 10'd140) begin n_fail++; $display("FAIL min_step3: got %0d required 140", car_x); end
        tick(8);
        n_checks++; if (car_x !== 10'd140) begin n_fail++; $display("FAIL min_hold: got %0d required 140", car_x); end
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h29) begin n_fail++; $display("FAIL status_move_l_min: got %h required 29", rd); end
        b_left = 0; tick(20);
        n_checks++; if (upd_cnt - base !== 3) begin n_fail++; $display("FAIL min_upd_count: got %0d required 3", upd_cnt - base); end
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h08) begin n_fail++; $display("FAIL status_idle_min: got %h required 08", rd); end
    endtask

    task automatic test_blocked();
        logic [31:0] rd;
        wb_write(4'd1, 32'd300, 4'hF);
        tick(3);
        b_left = 1; b_right = 1;
        tick(7);
        n_checks++; if (car_x !== 10'd300) begin n_fail++; $display("FAIL blocked_no_move: got %0d required 300", car_x); end
        tick(5);
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h63) begin n_fail++; $display("FAIL status_blocked: got %h required 63", rd); end
        b_right = 0;
        tick(6);
        n_checks++; if (car_x !== 10'd300) begin n_fail++; $display("FAIL unblock_pre: got %0d required 300", car_x); end
        tick(1);
        n_checks++; if (car_x !== 10'd296) begin n_fail++; $display("FAIL unblock_step: got %0d required 296", car_x); end
        b_left = 0; tick(20);
        n_checks++; if (car_x !== 10'd296) begin n_fail++; $display("FAIL unblock_release: got %0d required 296", car_x); end
    endtask

    task automatic test_write_vs_step();
        logic [31:0] rd;
        b_right = 1;
        tick(7);
        n_checks++; if (car_x !== 10'd300) begin n_fail++; $display("FAIL right_step1: got %0d required 300", car_x); end
        tick(6);
        // write commits on the same edge as the second right step
        wb_write(4'd1, 32'd500, 4'hF);
        n_checks++; if (car_x !== 10'd460) begin n_fail++; $display("FAIL write_beats_step: got %0d required 460", car_x); end
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h52) begin n_fail++; $display("FAIL status_move_r_max: got %h required 52", rd); end
        b_right = 0; tick(20);
        n_checks++; if (car_x !== 10'd460) begin n_fail++; $display("FAIL max_hold: got %0d required 460", car_x); end
    endtask

    task automatic test_ctrl();
        logic [31:0] rd;
        int unsigned base;
        wb_write(4'd0, 32'h1, 4'hF);
        wb_write(4'd1, 32'd300, 4'hF);
        b_right = 1; tick(30);
        n_checks++; if (car_x !== 10'd300) begin n_fail++; $display("FAIL step_zero: got %0d required 300", car_x); end
        b_right = 0; tick(20);
        wb_read(4'd0, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ctrl_step0: got %h required 1", rd); end
        wb_write(4'd0, 32'h0001_0401, 4'hF);
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL ctrl_recentre: got %0d required 269", car_x); end
        wb_read(4'd0, rd);
        n_checks++; if (rd !== 32'h401) begin n_fail++; $display("FAIL ctrl_readback: got %h required 401", rd); end
        wb_write(4'd1, 32'h0, 4'b0001);
        n_checks++; if (car_x !== 10'd256) begin n_fail++; $display("FAIL pos_byte_sel: got %0d required 256", car_x); end
        tick(3); base = upd_cnt;
        wb_write(4'd1, 32'd256, 4'hF);
        tick(5);
        n_checks++; if (upd_cnt - base !== 0) begin n_fail++; $display("FAIL same_write_upd: got %0d required 0", upd_cnt - base); end
        b_centre = 1;
        tick(6);
        n_checks++; if (car_x !== 10'd256) begin n_fail++; $display("FAIL centre_pre: got %0d required 256", car_x); end
        tick(1);
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL centre_button: got %0d required 269", car_x); end
        b_centre = 0; tick(10);
        wb_write(4'd0, 32'h400, 4'hF);
        b_left = 1; tick(20);
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL disabled_no_move: got %0d required 269", car_x); end
        wb_read(4'd2, rd);
        n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL status_disabled: got %h required 01", rd); end
        b_left = 0; tick(10);
        wb_write(4'd0, 32'h401, 4'hF);
    endtask

    task automatic test_back_to_back();
        cyc = 1; stb = 1; we = 0; adr = 32'h8; sel = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ack !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL b2b_ack[%0d]: got %b required %b", i, ack, (i % 2) == 0);
            end
        end
        cyc = 0; stb = 0; tick(2);
    endtask

    task automatic test_reset_midtransfer();
        logic [31:0] rd;
        cyc = 1; stb = 1; we = 1; adr = 32'h4; dat_w = 32'd300; sel = 4'hF;
        tick(1);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_up: got %b required 1", ack); end
        rst = 1;
        tick(1);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack_drop: got %b required 0", ack); end
        n_checks++; if (car_x !== 10'd269) begin n_fail++; $display("FAIL mid_write_discard: got %0d required 269", car_x); end
        cyc = 0; stb = 0; we = 0;
        tick(1); rst = 0; tick(2);
        wb_read(4'd1, rd);
        n_checks++; if (rd !== 32'd269) begin n_fail++; $display("FAIL mid_pos: got %0d required 269", rd); end
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat_w = '0; sel = '0;
        b_left = 0; b_right = 0; b_centre = 0;
        test_reset();
        test_hold_left();
        test_clamp_min();
        test_blocked();
        test_write_vs_step();
        test_ctrl();
        test_back_to_back();
        test_reset_midtransfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
